// File: rtl/pe_mode_mac.sv
// Mode-selectable systolic MAC processing element (weight-stationary or output-stationary).
// Optional macro PE_SATURATE_EN: clamp WS sums and OS accumulation instead of wrapping.
module pe_mode_mac #(
    parameter int OPERAND_WIDTH    = 8,
    parameter int ACCUMULATE_WIDTH = 16
) (
    input  logic                               clk_i,
    input  logic                               reset,
    input  logic                               start_i,
    input  logic                               mode_i,
    input  logic                               stop_i,
    input  logic                               w_load_i,
    input  logic                               drain_i,
    input  logic                               valid_i,
    input  logic signed [OPERAND_WIDTH-1:0]    A_in,
    input  logic signed [OPERAND_WIDTH-1:0]    B_in,
    input  logic signed [ACCUMULATE_WIDTH-1:0] Partial_Sum_in,
    output logic signed [OPERAND_WIDTH-1:0]    A_out,
    output logic signed [OPERAND_WIDTH-1:0]    B_out,
    output logic signed [ACCUMULATE_WIDTH-1:0] Partial_Sum_out,
    output logic                               valid_o,
    output logic [1:0]                         state_o,
    output logic                               ovf_o
);

    localparam int PW = 2 * OPERAND_WIDTH;
    localparam int AW = ACCUMULATE_WIDTH;
    localparam logic signed [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WS_LOAD = 2'd1,
        ST_WS_RUN  = 2'd2,
        ST_OS_RUN  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic signed [OPERAND_WIDTH-1:0] weight_reg, weight_next;
    logic signed [AW-1:0]  acc_reg, acc_next;
    logic                  ovf_reg, ovf_next;
    logic signed [AW-1:0]  ps_reg, ps_next;
    logic                  valid_reg, valid_next;
    logic signed [OPERAND_WIDTH-1:0] a_reg, b_reg;

    logic signed [PW-1:0]  ws_prod, os_prod;
    logic signed [AW-1:0]  ws_prod_ext, os_prod_ext;
    logic [AW:0]           ws_add, os_add;

    assign ws_prod     = A_in * weight_reg;
    assign os_prod     = A_in * B_in;
    assign ws_prod_ext = AW'(ws_prod);
    assign os_prod_ext = AW'(os_prod);

    // Returns {overflow, sum}; overflow when both addends share a sign the result lacks.
    function automatic logic [AW:0] add_chk(input logic signed [AW-1:0] a,
                                            input logic signed [AW-1:0] b);
        logic signed [AW-1:0] s;
        logic                 ov;
        s  = a + b;
        ov = (a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]);
`ifdef PE_SATURATE_EN
        if (ov) begin
            s = a[AW-1] ? SUM_MIN : SUM_MAX;
        end
`endif
        return {ov, s};
    endfunction

    assign ws_add = add_chk(Partial_Sum_in, ws_prod_ext);
    assign os_add = add_chk(acc_reg, os_prod_ext);

    always_comb begin
        state_next  = state_reg;
        weight_next = weight_reg;
        acc_next    = acc_reg;
        ovf_next    = ovf_reg;
        ps_next     = Partial_Sum_in;
        valid_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (drain_i) begin
                    ps_next  = acc_reg;
                    acc_next = '0;
                end
                if (start_i) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = mode_i ? ST_OS_RUN : ST_WS_LOAD;
                end
            end
            ST_WS_LOAD: begin
                if (stop_i) begin
                    state_next = ST_IDLE;
                end else if (w_load_i) begin
                    weight_next = B_in;
                    state_next  = ST_WS_RUN;
                end
            end
            ST_WS_RUN: begin
                valid_next = valid_i;
                if (valid_i) begin
                    ps_next = ws_add[AW-1:0];
                    if (ws_add[AW]) ovf_next = 1'b1;
                end
                if (stop_i) state_next = ST_IDLE;
            end
            ST_OS_RUN: begin
                valid_next = valid_i;
                if (drain_i) begin
                    // Drain emits the pre-update value; a coincident product seeds the new sum.
                    ps_next  = acc_reg;
                    acc_next = valid_i ? os_prod_ext : '0;
                end else if (valid_i) begin
                    acc_next = os_add[AW-1:0];
                    if (os_add[AW]) ovf_next = 1'b1;
                end
                if (stop_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            weight_reg <= '0;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
            ps_reg     <= '0;
            valid_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            weight_reg <= weight_next;
            acc_reg    <= acc_next;
            ovf_reg    <= ovf_next;
            ps_reg     <= ps_next;
            valid_reg  <= valid_next;
            a_reg      <= A_in;
            b_reg      <= B_in;
        end
    end

    assign A_out           = a_reg;
    assign B_out           = b_reg;
    assign Partial_Sum_out = ps_reg;
    assign valid_o         = valid_reg;
    assign state_o         = state_reg;
    assign ovf_o           = ovf_reg;

endmodule

// File: tb/tb_pe_mode_mac.sv
// Directed testbench for pe_mode_mac: reset, WS, OS accumulate/drain, overflow, mid-run reset.
module tb_pe_mode_mac;

    logic               clk_tb = 1'b0;
    logic               reset;
    logic               start_i, mode_i, stop_i, w_load_i, drain_i, valid_i;
    logic signed [7:0]  A_in, B_in;
    logic signed [15:0] Partial_Sum_in;
    logic signed [7:0]  A_out, B_out;
    logic signed [15:0] Partial_Sum_out;
    logic               valid_o;
    logic [1:0]         state_o;
    logic               ovf_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk_tb = ~clk_tb;

    pe_mode_mac #(.OPERAND_WIDTH(8), .ACCUMULATE_WIDTH(16)) dut (
        .clk_i          (clk_tb),
        .reset          (reset),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .stop_i         (stop_i),
        .w_load_i       (w_load_i),
        .drain_i        (drain_i),
        .valid_i        (valid_i),
        .A_in           (A_in),
        .B_in           (B_in),
        .Partial_Sum_in (Partial_Sum_in),
        .A_out          (A_out),
        .B_out          (B_out),
        .Partial_Sum_out(Partial_Sum_out),
        .valid_o        (valid_o),
        .state_o        (state_o),
        .ovf_o          (ovf_o)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; mode_i = 0; stop_i = 0; w_load_i = 0; drain_i = 0; valid_i = 0;
        A_in = 0; B_in = 0; Partial_Sum_in = 0;
    endtask

    task automatic os_mac(input logic signed [7:0] a, input logic signed [7:0] b);
        valid_i = 1; A_in = a; B_in = b;
        tick();
        valid_i = 0;
    endtask

    longint ovf_drain_exp;

    initial begin
        idle_inputs();
`ifdef PE_SATURATE_EN
        ovf_drain_exp = 32767;
`else
        ovf_drain_exp = -17149;
`endif
        // 1. Reset with nonzero inputs
        reset = 1; valid_i = 1; A_in = 9; B_in = -4; Partial_Sum_in = 123; start_i = 1;
        tick(); tick();
        chk("rst_ps", Partial_Sum_out, 0);
        chk("rst_a", A_out, 0);
        chk("rst_b", B_out, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_ovf", ovf_o, 0);
        reset = 0; start_i = 0; Partial_Sum_in = 55;
        tick();
        chk("idle_valid", valid_o, 0);
        chk("idle_pass", Partial_Sum_out, 55);
        chk("idle_a", A_out, 9);

        // 2. Weight-stationary
        idle_inputs();
        start_i = 1; mode_i = 0;
        tick();
        chk("ws_load_state", state_o, 1);
        start_i = 0; w_load_i = 1; B_in = 3;
        tick();
        chk("ws_run_state", state_o, 2);
        w_load_i = 0; valid_i = 1; A_in = 2; Partial_Sum_in = 10;
        tick();
        chk("ws_sum", Partial_Sum_out, 16);
        chk("ws_a_out", A_out, 2);
        chk("ws_valid", valid_o, 1);
        w_load_i = 1; B_in = 5; A_in = -1; Partial_Sum_in = 0;
        tick();
        chk("ws_wload_ign", Partial_Sum_out, -3);
        chk("ws_b_out", B_out, 5);
        w_load_i = 0; valid_i = 0; A_in = 7; Partial_Sum_in = 77;
        tick();
        chk("ws_novalid", Partial_Sum_out, 77);
        chk("ws_novalid_v", valid_o, 0);
        stop_i = 1;
        tick();
        chk("ws_stop", state_o, 0);

        // stop beats w_load in WS_LOAD
        idle_inputs();
        start_i = 1;
        tick();
        start_i = 0; stop_i = 1; w_load_i = 1; B_in = 4;
        tick();
        chk("stop_prio", state_o, 0);

        // 3. Output-stationary accumulate and drain
        idle_inputs();
        start_i = 1; mode_i = 1;
        tick();
        chk("os_state", state_o, 3);
        start_i = 0; mode_i = 0; Partial_Sum_in = 21;
        os_mac(-20, 15);
        chk("os_shift", Partial_Sum_out, 21);
        chk("os_valid", valid_o, 1);
        os_mac(5, 5);
        drain_i = 1;
        tick();
        chk("os_drain1", Partial_Sum_out, -275);
        tick();
        chk("os_drain2", Partial_Sum_out, 0);
        drain_i = 0;
        chk("os_ovf0", ovf_o, 0);

        // 4. Drain coincident with valid, then retained-on-stop + IDLE drain
        os_mac(4, 4);
        drain_i = 1; valid_i = 1; A_in = 2; B_in = 3;
        tick();
        chk("dv_drain", Partial_Sum_out, 16);
        valid_i = 0;
        tick();
        chk("dv_next", Partial_Sum_out, 6);
        drain_i = 0;
        os_mac(3, 3);
        stop_i = 1;
        tick();
        chk("os_stop", state_o, 0);
        stop_i = 0; drain_i = 1; Partial_Sum_in = 100;
        tick();
        chk("idle_drain", Partial_Sum_out, 9);
        drain_i = 0;
        tick();
        chk("idle_pass2", Partial_Sum_out, 100);

        // 5. Overflow
        idle_inputs();
        start_i = 1; mode_i = 1;
        tick();
        start_i = 0;
        os_mac(127, 127);
        os_mac(127, 127);
        chk("ovf_pre", ovf_o, 0);
        os_mac(127, 127);
        chk("ovf_set", ovf_o, 1);
        drain_i = 1;
        tick();
        chk("ovf_drain", Partial_Sum_out, ovf_drain_exp);
        drain_i = 0; stop_i = 1;
        tick();
        chk("ovf_sticky", ovf_o, 1);
        stop_i = 0; start_i = 1; mode_i = 0;
        tick();
        chk("ovf_clear", ovf_o, 0);

        // WS overflow: 127*127 + 30000
        start_i = 0; w_load_i = 1; B_in = 127;
        tick();
        w_load_i = 0; valid_i = 1; A_in = 127; Partial_Sum_in = 30000;
        tick();
`ifdef PE_SATURATE_EN
        chk("ws_ovf_sum", Partial_Sum_out, 32767);
`else
        chk("ws_ovf_sum", Partial_Sum_out, 46129 - 65536);
`endif
        chk("ws_ovf_flag", ovf_o, 1);

        // 6. Reset mid-run with weight 3
        idle_inputs();
        stop_i = 1;
        tick();
        stop_i = 0; start_i = 1;
        tick();
        start_i = 0; w_load_i = 1; B_in = 3;
        tick();
        w_load_i = 0; reset = 1; valid_i = 1; A_in = 2; Partial_Sum_in = 40;
        tick();
        chk("mid_rst_ps", Partial_Sum_out, 0);
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        reset = 0; Partial_Sum_in = 7;
        tick();
        chk("post_rst_ps", Partial_Sum_out, 7);
        chk("post_rst_valid", valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/pe_mode_mac.md
Name: pe_mode_mac

Overview:
Parametrised, mode-selectable successor to the basic systolic MAC processing element for the torus systolic array.
- Supports weight-stationary (WS) operation: a preloaded weight, with partial sums flowing through the PE.
- Supports output-stationary (OS) operation: a local accumulator that is drained onto the partial-sum chain.
- Adds valid propagation, a small control FSM and optional saturating arithmetic.
- One instance per array cell; neighbours connect through A/B/Partial_Sum ports.

Parameters:
- OPERAND_WIDTH, 8, signed width of A/B operands and stored weight.
- ACCUMULATE_WIDTH, 16, signed width of partial sums and accumulator; must be >= 2*OPERAND_WIDTH.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start_i  input  1  in IDLE: begin operation in mode_i
- mode_i  input  1  0 = WS, 1 = OS; sampled only with start_i in IDLE
- stop_i  input  1  return to IDLE from any run state
- w_load_i  input  1  WS_LOAD: capture B_in as weight
- drain_i  input  1  place accumulator on Partial_Sum_out and clear it; honoured in OS_RUN and IDLE
- valid_i  input  1  A_in/B_in/Partial_Sum_in valid this cycle
- A_in  input  OPERAND_WIDTH  signed operand A
- B_in  input  OPERAND_WIDTH  signed operand B / weight source
- Partial_Sum_in  input  ACCUMULATE_WIDTH  signed upstream partial sum
- A_out  output  OPERAND_WIDTH  registered A_in
- B_out  output  OPERAND_WIDTH  registered B_in
- Partial_Sum_out  output  ACCUMULATE_WIDTH  registered result / forwarded sum
- valid_o  output  1  registered valid_i, gated by run state
- state_o  output  2  current FSM state encoding
- ovf_o  output  1  sticky overflow flag

Behaviour:
Reset and FSM:
- Reset (synchronous, active-high, wins over all inputs): all outputs 0, weight 0, accumulator 0, state IDLE.
- States and encodings: IDLE=0, WS_LOAD=1, WS_RUN=2, OS_RUN=3.
- IDLE + start_i: mode_i=0 → WS_LOAD; mode_i=1 → OS_RUN. Accumulator and ovf_o are cleared in both cases.
- WS_LOAD + w_load_i: weight <= B_in, go to WS_RUN.
- w_load_i in any other state is ignored.
- stop_i in any non-IDLE state → IDLE next cycle; stop_i has priority over w_load_i.
- start_i outside IDLE is ignored.
- The accumulator is retained on stop; it is cleared only by drain, start or reset.

Data path (all outputs registered, 1-cycle latency):
- A_out <= A_in and B_out <= B_in every cycle in every state, valid or not.
- valid_o <= valid_i in WS_RUN/OS_RUN; 0 otherwise.
- IDLE/WS_LOAD: Partial_Sum_out <= Partial_Sum_in (pass-through), except an IDLE drain_i.
- WS_RUN:
  - valid_i=1: Partial_Sum_out <= Partial_Sum_in + A_in*weight.
  - valid_i=0: Partial_Sum_out <= Partial_Sum_in.
- OS_RUN:
  - valid_i=1: acc <= acc + A_in*B_in.
  - Partial_Sum_out <= Partial_Sum_in (shift chain), unless drain_i.
- drain_i: Partial_Sum_out <= acc (pre-update value), acc <= 0.
  - If valid_i is also high in OS_RUN: acc <= A_in*B_in (new product not lost).

Arithmetic:
- Product is signed 2*OPERAND_WIDTH, sign-extended to ACCUMULATE_WIDTH.
- Sums wrap modulo 2^ACCUMULATE_WIDTH by default.
- ovf_o is set when any WS sum or OS accumulation overflows signed range.
- ovf_o stays set until reset or start_i.

Optional Feature:
Macro PE_SATURATE_EN.
- Defined: WS sums and OS accumulation clamp to signed max (2^(ACCUMULATE_WIDTH-1)-1) or min (-2^(ACCUMULATE_WIDTH-1)) on overflow; ovf_o still set.
- Undefined: two's-complement wrap; ovf_o still reports overflow.
- Ports are identical either way.

Test Plan:
1. Reset: hold reset 2 cycles with nonzero inputs → all outputs 0, state_o=0; release, valid_i=1 without start → valid_o=0, Partial_Sum_out = Partial_Sum_in.
2. WS: start_i mode_i=0; w_load_i with B_in=3 → state_o=2; then valid A_in=2, Partial_Sum_in=10 → next cycle Partial_Sum_out=16, A_out=2, valid_o=1.
3. OS accumulate/drain: start_i mode_i=1; valid (-20,15) then (5,5) → acc=-275; drain_i → Partial_Sum_out=-275 one cycle later; second drain → 0.
4. Drain plus valid: OS acc=16, drain_i with valid A=2, B=3 → Partial_Sum_out=16, next drain gives 6.
5. Overflow (OPERAND_WIDTH=8, ACCUMULATE_WIDTH=16): OS, three valid (127,127) → wrap build: acc drains -17149, ovf_o=1; PE_SATURATE_EN build: drains 32767, ovf_o=1.
6. Reset mid-run: in WS_RUN with weight=3, assert reset 1 cycle → outputs 0, state IDLE, weight 0; following valid A=2 without start → Partial_Sum_out = Partial_Sum_in, valid_o=0.
